// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: two-state fetch/execute sequencer owning the PC and next-PC selection
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        jump,
  input  logic        alu_zero,
  input  logic        exec_done
);
  typedef enum logic {REQ, EXEC} state_t;
  state_t state, state_nxt;
  logic run, fetch, retire, branch_taken;
  logic [31:0] branch_target, jump_target, next_pc;
  // run stays low until the first edge after reset so the request line is quiet while in reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) run <= 1'b0;
    else run <= 1'b1;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= REQ;
    else state <= state_nxt;
  // handshake decode and next state; exec_done is ignored in REQ, imem_ready in EXEC
  always_comb begin
    imem_req = run & (state == REQ);
    instr_valid = state == EXEC;
    fetch = imem_req & imem_ready;
    retire = instr_valid & exec_done;
    state_nxt = fetch ? EXEC : retire ? REQ : state;
  end
  // next-PC selection: jump beats a taken branch, otherwise fall through
  always_comb begin
    pc_plus4 = pc + 32'd4;
    branch_taken = branch & (alu_zero ^ instr[28]);
    branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
    next_pc = jump ? jump_target : branch_taken ? branch_target : pc_plus4;
  end
  assign imem_addr = pc;
  assign opcode = instr[31:26];
  // instruction register loads only on an accepted fetch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) instr <= '0;
    else if (fetch) instr <= imem_rdata;
  // PC advances only when the current instruction retires; all targets stay word-aligned
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= {RESET_PC[31:2], 2'b00};
    else if (retire) pc <= next_pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed table, random run against a transaction model, reset corner cases
module tb_instr_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_ready = 1'b0, branch = 1'b0, jump = 1'b0, alu_zero = 1'b0, exec_done = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, instr_valid, hi_req, hi_valid;
  logic [31:0] imem_addr, instr, pc, pc_plus4, hi_addr, hi_instr, hi_pc, hi_pc4;
  logic [5:0] opcode, hi_opcode;
  int cmp_cnt = 0, fail_cnt = 0;
  logic m_run, m_have;
  logic [31:0] m_pc, m_instr;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .branch(branch),
    .jump(jump), .alu_zero(alu_zero), .exec_done(exec_done)
  );

  instr_fetch_unit #(.RESET_PC(32'h3000_0000)) u_hi (
    .clk(clk), .rst_n(rst_n), .imem_req(hi_req), .imem_addr(hi_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(hi_instr), .opcode(hi_opcode),
    .instr_valid(hi_valid), .pc(hi_pc), .pc_plus4(hi_pc4), .branch(branch),
    .jump(jump), .alu_zero(alu_zero), .exec_done(exec_done)
  );

  typedef struct {
    logic rdy; logic [31:0] rd; logic br, jp, z, dn;
    logic [31:0] epc; logic ev;
  } vec_t;
  vec_t tbl[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_have = 1'b0; m_pc = 32'h0; m_instr = 32'h0;
  endtask

  function automatic logic [31:0] model_next_pc();
    logic [31:0] p4, tgt;
    int off;
    p4 = m_pc + 32'd4;
    if (jump) return (p4 & 32'hF000_0000) + (m_instr & 32'h03FF_FFFF) * 4;
    off = int'($signed(m_instr[15:0]));
    tgt = p4 + 32'(off * 4);
    if (branch && ((alu_zero != 1'b0) != (m_instr[28] != 1'b0))) return tgt;
    return p4;
  endfunction

  task automatic check_all();
    check("imem_req", 32'(imem_req), 32'(m_run && !m_have));
    check("imem_addr", imem_addr, m_pc);
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("instr", instr, m_instr);
    check("opcode", 32'(opcode), m_instr >> 26);
    check("instr_valid", 32'(instr_valid), 32'(m_have));
  endtask

  task automatic tick();
    logic run_n, have_n;
    logic [31:0] pc_n, instr_n;
    run_n = 1'b1; have_n = m_have; pc_n = m_pc; instr_n = m_instr;
    if (m_run && !m_have && imem_ready) begin
      have_n = 1'b1; instr_n = imem_rdata;
    end else if (m_have && exec_done) begin
      have_n = 1'b0; pc_n = model_next_pc();
    end
    @(posedge clk); #1;
    m_run = run_n; m_have = have_n; m_pc = pc_n; m_instr = instr_n;
    check_all();
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rd, input logic br, input logic jp,
                       input logic z, input logic dn);
    imem_ready = rdy; imem_rdata = rd; branch = br; jump = jp; alu_zero = z; exec_done = dn;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h4,         1'b0};
    tbl[3]  = '{1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h4,         1'b1};
    tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h8,         1'b0};
    tbl[5]  = '{1'b1, 32'h4,         1'b0, 1'b0, 1'b0, 1'b0, 32'h8,         1'b1};
    tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h10,        1'b0};
    tbl[7]  = '{1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10,        1'b0};
    tbl[8]  = '{1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10,        1'b0};
    tbl[9]  = '{1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10,        1'b0};
    tbl[10] = '{1'b1, 32'h8,         1'b0, 1'b0, 1'b0, 1'b0, 32'h10,        1'b1};
    tbl[11] = '{1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h10,        1'b1};
    tbl[12] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h20,        1'b0};
    tbl[13] = '{1'b1, 32'h8C00_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,        1'b1};
    tbl[14] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'h1C,        1'b0};
    tbl[15] = '{1'b1, 32'h9C00_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1C,        1'b1};
    tbl[16] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'h20,        1'b0};
    tbl[17] = '{1'b1, 32'h9C00_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,        1'b1};
    tbl[18] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h34,        1'b0};
    tbl[19] = '{1'b1, 32'h1000_FFF1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h34,        1'b1};
    tbl[20] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0};
    tbl[21] = '{1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1};
    tbl[22] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0};
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rdy, tbl[i].rd, tbl[i].br, tbl[i].jp, tbl[i].z, tbl[i].dn);
      tick();
      check($sformatf("tbl%0d_pc", i), pc, tbl[i].epc);
      check($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].ev));
    end
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom), $urandom_range(0, 9) < 6);
      tick();
    end
    drive(1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4 && !m_have; i++) tick();
    check("reach_exec", 32'(instr_valid), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("hi_reset_pc", hi_pc, 32'h3000_0000);
    check("hi_reset_req", 32'(hi_req), 32'd0);
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
    drive(1'b1, 32'h03FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("hi_first_addr", hi_addr, 32'h3000_0000);
    tick();
    check("hi_valid", 32'(hi_valid), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check("hi_jump_pc", hi_pc, 32'h3FFF_FFFC);
    check("lo_jump_pc", pc, 32'h0FFF_FFFC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n as everywhere in the codebase.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  fetch address; equals pc.
REQ-007 imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  registered current instruction.
REQ-010 opcode  output  6  instr[31:26]; drives the control unit's opcode input.
REQ-011 instr_valid  output  1  instr is valid for decode/execute.
REQ-012 pc  output  32  address of the current instruction.
REQ-013 pc_plus4  output  32  pc + 4, modulo 2^32; link value for JAL.
REQ-014 branch  input  1  from the control unit.
REQ-015 jump  input  1  from the control unit.
REQ-016 alu_zero  input  1  ALU zero flag for the current instruction.
REQ-017 exec_done  input  1  datapath has completed the current instruction.

Function
REQ-018 The block SHALL implement a 2-state FSM: REQ and EXEC.
REQ-019 In REQ, imem_req SHALL be 1, instr_valid SHALL be 0, and pc SHALL be held.
REQ-020 In REQ with imem_ready=1, the block SHALL load imem_rdata into instr and move to EXEC on the next edge.
REQ-021 In REQ with imem_ready=0, the block SHALL remain in REQ with no limit on wait cycles.
REQ-022 In EXEC, imem_req SHALL be 0, instr_valid SHALL be 1, and instr and pc SHALL be stable.
REQ-023 In EXEC with exec_done=1, the block SHALL load next_pc into pc and return to REQ.
REQ-024 In EXEC with exec_done=0, the block SHALL hold all state.
REQ-025 exec_done SHALL be ignored in REQ, and imem_ready SHALL be ignored in EXEC.
REQ-026 Branch polarity SHALL be taken from instr[28]: 0 is BEQ (opcode 100011) and 1 is BNE (opcode 100111).
REQ-027 branch_taken SHALL be branch & (alu_zero XOR instr[28]).
REQ-028 The branch target SHALL be pc_plus4 + (sign-extended instr[15:0] << 2), with 32-bit wrap-around.
REQ-029 The jump target SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-030 next_pc priority SHALL be: jump target if jump=1, else branch target if branch_taken=1, else pc_plus4.
REQ-031 jump and branch SHALL be sampled only in the EXEC cycle where exec_done=1.
REQ-032 Fetch-to-instr_valid latency SHALL be 1 cycle after the imem_ready cycle.
REQ-033 A minimum instruction SHALL take 2 cycles: REQ with ready, then EXEC with done.
REQ-034 pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 on a sequential fetch.
REQ-035 pc[1:0] SHALL always be 2'b00, since all targets are word-aligned by construction.

Reset
REQ-036 On rst_n=0, the block SHALL asynchronously set pc=RESET_PC, instr=0, state=REQ, and instr_valid=0.
REQ-037 During reset, imem_req SHALL be 0.
REQ-038 Following the first clk edge with rst_n=1, the block SHALL behave as REQ and assert imem_req.
REQ-039 Reset asserted in any state, including mid-wait or in EXEC with exec_done=1, SHALL override every update.
REQ-040 After reset is released, the first fetch SHALL be at RESET_PC.

Verification
REQ-041 Reset then sequential run: ready=1 and done=1 each cycle -> imem_addr 0x0, 0x4, 0x8 on successive REQ cycles; instr_valid toggles 0/1.
REQ-042 Memory wait: imem_ready held 0 for 3 cycles at pc=0x10 -> imem_req stays 1 and pc stays 0x10; instr loads on the 4th cycle.
REQ-043 BEQ taken: pc=0x20, instr=0x8C00_FFFE, branch=1, zero=1 -> next pc=0x1C.
REQ-044 BNE: instr=0x9C00_0004, branch=1 -> with zero=1 next pc=pc+4; with zero=0 next pc=pc+0x14.
REQ-045 Jump and wrap: pc=0x3000_0000 with JUMP instr[25:0]=0x3FF_FFFF -> pc=0x3FFF_FFFC; sequential fetch at pc=0xFFFF_FFFC -> pc=0x0.
REQ-046 Reset mid-operation: rst_n low during EXEC with exec_done=1 -> pc=RESET_PC, instr_valid=0 immediately, with no next_pc update.
